// File: rtl/mult_wb_merge_pkg.sv
// rtl/mult_wb_merge_pkg.sv - shared depth/pointer parameters and port-select encoding for the writeback merge
package mult_wb_merge_pkg;

    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_PTR_W      = $clog2(WB_FIFO_DEPTH);

    // Which source owns the register-file write port this cycle
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_MAIN   = 2'd1,
        SEL_FIFO   = 2'd2,
        SEL_BYPASS = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/mult_wb_merge_wb_fifo.sv
// rtl/mult_wb_merge_wb_fifo.sv - multiply-result ring buffer with per-address invalidate and youngest-match lookup
module wb_fifo
    import mult_wb_merge_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = WB_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              inv_en,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count_next,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic [DEPTH-1:0]  vld;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  idx;

    assign empty      = (cnt == '0);
    assign full       = (cnt == CNT_W'(DEPTH));
    assign count_next = cnt + CNT_W'(push) - CNT_W'(pop);
    assign head_valid = vld[rd_ptr];
    assign head_addr  = addr_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

    // Pop clears before push sets, so a full push+pop on the same slot keeps the new entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inv_en && (addr_q[i] == inv_addr)) begin
                    vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            cnt <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (vld[idx] && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/mult_wb_merge.sv
// rtl/mult_wb_merge.sv - merges multiply results with main writeback onto one RF port (option: MULT_OVF_TRAP_EN)
module mult_wb_merge
    import mult_wb_merge_pkg::*;
#(
    parameter int REG_ADDR = 5,
    parameter int REG_SIZE = 32,
    parameter int DEPTH    = WB_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mult_we,
    input  logic [REG_ADDR-1:0] mult_waddr,
    input  logic [REG_SIZE-1:0] mult_wdata,
    input  logic                mult_ovf,
    input  logic                main_we,
    input  logic [REG_ADDR-1:0] main_waddr,
    input  logic [REG_SIZE-1:0] main_wdata,
    input  logic [REG_ADDR-1:0] lookup_addr,
    output logic                rf_we,
    output logic [REG_ADDR-1:0] rf_waddr,
    output logic [REG_SIZE-1:0] rf_wdata,
    output logic                stall_mult,
    output logic                lookup_hit,
    output logic [REG_SIZE-1:0] lookup_data,
    output logic                err_drop
`ifdef MULT_OVF_TRAP_EN
    ,
    output logic                ovf_trap
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_sel_e             sel;
    logic                main_ok;
    logic                mult_kill;
    logic                mult_ok;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                drop;
    logic                fifo_empty;
    logic                fifo_full;
    logic                head_valid;
    logic [REG_ADDR-1:0] head_addr;
    logic [REG_SIZE-1:0] head_data;
    logic [CNT_W-1:0]    count_next;
    logic                fifo_hit;
    logic [REG_SIZE-1:0] fifo_hit_data;

    assign main_ok   = main_we && (main_waddr != '0);
    // Main pipe is younger, so a same-cycle mult to the same register is stale
    assign mult_kill = main_ok && (mult_waddr == main_waddr);

`ifdef MULT_OVF_TRAP_EN
    assign mult_ok = mult_we && !mult_ovf && (mult_waddr != '0) && !mult_kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_trap <= 1'b0;
        end else begin
            ovf_trap <= mult_we && mult_ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = mult_ovf;
    assign mult_ok    = mult_we && (mult_waddr != '0) && !mult_kill;
`endif

    always_comb begin
        sel = SEL_NONE;
        if (main_ok) begin
            sel = SEL_MAIN;
        end else if (!fifo_empty) begin
            sel = SEL_FIFO;
        end else if (mult_ok) begin
            sel = SEL_BYPASS;
        end
    end

    assign pop      = (sel == SEL_FIFO);
    assign push_req = mult_ok && (sel != SEL_BYPASS);
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    wb_fifo #(
        .ADDR_W (REG_ADDR),
        .DATA_W (REG_SIZE),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (mult_waddr),
        .push_data   (mult_wdata),
        .pop         (pop),
        .inv_en      (main_ok),
        .inv_addr    (main_waddr),
        .lookup_addr (lookup_addr),
        .head_valid  (head_valid),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .count_next  (count_next),
        .hit         (fifo_hit),
        .hit_data    (fifo_hit_data)
    );

    // Invalidated heads pop as no-writes and leave address/data holding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= 1'b0;
            case (sel)
                SEL_MAIN: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= main_waddr;
                    rf_wdata <= main_wdata;
                end
                SEL_FIFO: begin
                    rf_we <= head_valid;
                    if (head_valid) begin
                        rf_waddr <= head_addr;
                        rf_wdata <= head_data;
                    end
                end
                SEL_BYPASS: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= mult_waddr;
                    rf_wdata <= mult_wdata;
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

    // Threshold leaves room for the one result already in flight when stall is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_mult <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            stall_mult <= (count_next >= CNT_W'(DEPTH - 1));
            if (drop) begin
                err_drop <= 1'b1;
            end
        end
    end

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        if (mult_ok && (mult_waddr == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = mult_wdata;
        end else if (fifo_hit) begin
            lookup_hit  = 1'b1;
            lookup_data = fifo_hit_data;
        end
    end

endmodule

// File: tb/tb_mult_wb_merge.sv
// tb/tb_mult_wb_merge.sv - vector table plus directed merge, stall, WAW, lookup and reset sequences
module tb_mult_wb_merge;

    logic        clk;
    logic        rst_n;
    logic        mult_we;
    logic [4:0]  mult_waddr;
    logic [31:0] mult_wdata;
    logic        mult_ovf;
    logic        main_we;
    logic [4:0]  main_waddr;
    logic [31:0] main_wdata;
    logic [4:0]  lookup_addr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_mult;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        err_drop;
`ifdef MULT_OVF_TRAP_EN
    logic        ovf_trap;
`endif

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    typedef struct {
        logic        main_we;
        logic [4:0]  main_waddr;
        logic [31:0] main_wdata;
        logic        mult_we;
        logic [4:0]  mult_waddr;
        logic [31:0] mult_wdata;
        logic        mult_ovf;
        int          n_exp;
        wr_t         e0;
        wr_t         e1;
    } vec_t;

    localparam int N_VEC = 8;
    vec_t vecs[N_VEC];

    mult_wb_merge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mult_we     (mult_we),
        .mult_waddr  (mult_waddr),
        .mult_wdata  (mult_wdata),
        .mult_ovf    (mult_ovf),
        .main_we     (main_we),
        .main_waddr  (main_waddr),
        .main_wdata  (main_wdata),
        .lookup_addr (lookup_addr),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .stall_mult  (stall_mult),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .err_drop    (err_drop)
`ifdef MULT_OVF_TRAP_EN
        ,
        .ovf_trap    (ovf_trap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every RF write is matched in order against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rf_write_unexpected: got r%0d=0x%0h, required no write", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d) begin
                    n_errors++;
                    $display("FAIL rf_write: got r%0d=0x%0h, required r%0d=0x%0h",
                             rf_waddr, rf_wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic idle();
        main_we    = 1'b0;
        main_waddr = '0;
        main_wdata = '0;
        mult_we    = 1'b0;
        mult_waddr = '0;
        mult_wdata = '0;
        mult_ovf   = 1'b0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int n);
        repeat (n) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    function automatic vec_t mk(input logic mw, input logic [4:0] ma, input logic [31:0] md,
                                input logic xw, input logic [4:0] xa, input logic [31:0] xd,
                                input logic xo, input int ne,
                                input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1);
        vec_t v;
        v.main_we = mw; v.main_waddr = ma; v.main_wdata = md;
        v.mult_we = xw; v.mult_waddr = xa; v.mult_wdata = xd; v.mult_ovf = xo;
        v.n_exp = ne;
        v.e0.a = a0; v.e0.d = d0;
        v.e1.a = a1; v.e1.d = d1;
        return v;
    endfunction

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        lookup_addr = '0;
        idle();

        vecs[0] = mk(0, 0, 0,       1, 3,  32'h15, 0, 1, 3,  32'h15, 0, 0);
        vecs[1] = mk(1, 4, 32'hAA,  1, 5,  32'h7,  0, 2, 4,  32'hAA, 5, 32'h7);
        vecs[2] = mk(0, 0, 0,       1, 0,  32'hFF, 0, 0, 0,  0,      0, 0);
        vecs[3] = mk(1, 0, 32'h11,  0, 0,  0,      0, 0, 0,  0,      0, 0);
        vecs[4] = mk(1, 9, 32'h1,   1, 9,  32'h2,  0, 1, 9,  32'h1,  0, 0);
        vecs[5] = mk(1, 10, 32'h33, 0, 0,  0,      0, 1, 10, 32'h33, 0, 0);
        vecs[6] = mk(1, 0, 32'h44,  1, 6,  32'h66, 0, 1, 6,  32'h66, 0, 0);
`ifdef MULT_OVF_TRAP_EN
        vecs[7] = mk(0, 0, 0,       1, 7,  32'h77, 1, 0, 0,  0,      0, 0);
`else
        vecs[7] = mk(0, 0, 0,       1, 7,  32'h77, 1, 1, 7,  32'h77, 0, 0);
`endif

        repeat (2) @(negedge clk);
        check("reset_rf_we", rf_we, 0);
        check("reset_rf_waddr", rf_waddr, 0);
        check("reset_rf_wdata", rf_wdata, 0);
        check("reset_stall", stall_mult, 0);
        check("reset_err_drop", err_drop, 0);
        check("reset_lookup_hit", lookup_hit, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bypass: one-cycle latency, lookup sees the incoming result
        mult_we = 1; mult_waddr = 3; mult_wdata = 32'h15; lookup_addr = 3;
        expect_wr(3, 32'h15);
        #1;
        check("bypass_lookup_hit", lookup_hit, 1);
        check("bypass_lookup_data", lookup_data, 32'h15);
        @(negedge clk);
        idle();
        check("bypass_latency_we", rf_we, 1);
        check("bypass_no_stall", stall_mult, 0);
        drain("bypass_drain", 3);

        for (int i = 0; i < N_VEC; i++) begin
            main_we    = vecs[i].main_we;
            main_waddr = vecs[i].main_waddr;
            main_wdata = vecs[i].main_wdata;
            mult_we    = vecs[i].mult_we;
            mult_waddr = vecs[i].mult_waddr;
            mult_wdata = vecs[i].mult_wdata;
            mult_ovf   = vecs[i].mult_ovf;
            if (vecs[i].n_exp > 0) exp_q.push_back(vecs[i].e0);
            if (vecs[i].n_exp > 1) exp_q.push_back(vecs[i].e1);
            @(negedge clk);
            idle();
`ifdef MULT_OVF_TRAP_EN
            check($sformatf("vec%0d_ovf_trap", i), ovf_trap, vecs[i].mult_ovf);
`endif
            drain($sformatf("vec%0d_drain", i), 4);
        end

        // Main busy 6 cycles, mult for 4 (3 before stall seen + 1 in flight)
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c < 6) begin
                main_we = 1; main_waddr = 5'(24 + c); main_wdata = 32'h100 + c;
                expect_wr(5'(24 + c), 32'h100 + c);
            end
            if (c < 4) begin
                mult_we = 1; mult_waddr = 5'(8 + c); mult_wdata = 32'h200 + c;
            end
            if (c == 6) begin
                for (int k = 0; k < 4; k++) expect_wr(5'(8 + k), 32'h200 + k);
            end
            @(negedge clk);
            check($sformatf("stall_c%0d", c), stall_mult, (c >= 2 && c <= 6) ? 1 : 0);
        end
        idle();
        check("stall_no_drop", err_drop, 0);
        drain("stall_drain", 4);

        // Five pushes into a 4-deep FIFO with no pops: fifth is dropped
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 5) begin
                main_we = 1; main_waddr = 5'(24 + c); main_wdata = 32'h400 + c;
                expect_wr(5'(24 + c), 32'h400 + c);
                mult_we = 1; mult_waddr = 5'(8 + c); mult_wdata = 32'h500 + c;
            end
            if (c == 5) begin
                for (int k = 0; k < 4; k++) expect_wr(5'(8 + k), 32'h500 + k);
            end
            @(negedge clk);
            if (c == 3) check("drop_before_full", err_drop, 0);
            if (c == 4) check("drop_set", err_drop, 1);
        end
        idle();
        drain("drop_drain", 6);
        check("drop_sticky", err_drop, 1);

        // WAW: queued r7=0x1 is killed by a younger main write r7=0x2
        main_we = 1; main_waddr = 20; main_wdata = 32'h5;
        mult_we = 1; mult_waddr = 7; mult_wdata = 32'h1;
        expect_wr(20, 32'h5);
        @(negedge clk);
        idle();
        main_we = 1; main_waddr = 7; main_wdata = 32'h2; lookup_addr = 7;
        expect_wr(7, 32'h2);
        #1;
        check("waw_hit_before", lookup_hit, 1);
        check("waw_data_before", lookup_data, 32'h1);
        @(negedge clk);
        idle();
        #1;
        check("waw_hit_after", lookup_hit, 0);
        check("waw_data_after", lookup_data, 0);
        drain("waw_drain", 4);

        // Youngest match: incoming beats tail, tail beats head
        main_we = 1; main_waddr = 21; main_wdata = 32'hA1;
        mult_we = 1; mult_waddr = 12; mult_wdata = 32'hA;
        expect_wr(21, 32'hA1);
        @(negedge clk);
        main_waddr = 22; main_wdata = 32'hA2; mult_wdata = 32'hB; lookup_addr = 12;
        expect_wr(22, 32'hA2);
        #1;
        check("young_incoming", lookup_data, 32'hB);
        @(negedge clk);
        main_waddr = 23; main_wdata = 32'hA3; mult_we = 0;
        expect_wr(23, 32'hA3);
        expect_wr(12, 32'hA);
        expect_wr(12, 32'hB);
        #1;
        check("young_tail", lookup_data, 32'hB);
        lookup_addr = 13;
        #1;
        check("lookup_miss", lookup_hit, 0);
        @(negedge clk);
        idle();
        drain("young_drain", 4);

`ifdef MULT_OVF_TRAP_EN
        mult_we = 1; mult_waddr = 11; mult_wdata = 32'hBAD; mult_ovf = 1;
        @(negedge clk);
        idle();
        check("ovf_trap_pulse", ovf_trap, 1);
        check("ovf_no_write", rf_we, 0);
        @(negedge clk);
        check("ovf_trap_clear", ovf_trap, 0);
`endif

        // Asynchronous reset with three entries queued
        for (int c = 0; c < 3; c++) begin
            main_we = 1; main_waddr = 5'(17 + c); main_wdata = 32'h600 + c;
            mult_we = 1; mult_waddr = 5'(14 + c); mult_wdata = 32'h300 + c;
            expect_wr(5'(17 + c), 32'h600 + c);
            @(negedge clk);
        end
        idle();
        lookup_addr = 15;
        #1;
        check("rst_pre_stall", stall_mult, 1);
        check("rst_pre_hit", lookup_hit, 1);
        check("rst_pre_data", lookup_data, 32'h301);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_stall", stall_mult, 0);
        check("rst_err_drop", err_drop, 0);
        check("rst_lookup_hit", lookup_hit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drain("rst_no_writes", 5);
        check("rst_post_hit", lookup_hit, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
